// File: rtl/ftf12_radix_packer.sv
// Radix-377 packer: splits each accepted binary word into NDIG 9-bit digits,
// least-significant first, for the 12-line Fibonacci encoder.
module ftf12_radix_packer #(
  parameter int WORD_W = 32,
  parameter int NDIG   = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [8:0]        o_dig_data,
  output logic              o_dig_valid,
  input  logic              i_dig_ready,
  output logic              o_dig_first,
  output logic              o_dig_last,
  output logic              o_busy
);

  localparam int FBLEN12 = 9;
  localparam int RADIX   = 377;
  localparam int CNT_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int EXT_W   = WORD_W + FBLEN12;

  // True when NDIG radix-377 digits can represent every WORD_W-bit value.
  function automatic bit radix_covers();
    logic [79:0] cap;
    logic [79:0] lim;
    cap = 80'd1;
    lim = 80'd1 << WORD_W;
    for (int k = 0; k < NDIG && cap < lim; k++) cap = cap * 80'd377;
    return cap >= lim;
  endfunction

  localparam bit COVERS = radix_covers();

  if (WORD_W < 1 || WORD_W > 64) begin : g_bad_width
    $error("ftf12_radix_packer: WORD_W must lie in 1..64");
  end
  if (NDIG < 1 || !COVERS) begin : g_bad_ndig
    $error("ftf12_radix_packer: 377**NDIG must be >= 2**WORD_W");
  end

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WORD_W-1:0]       r_residue, w_residue_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [FBLEN12-1:0]      r_dig_data, w_dig_data_nxt;
  logic                    r_dig_first, w_dig_first_nxt;
  logic                    r_dig_last, w_dig_last_nxt;

  logic                    w_dig_valid;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_take;
  logic [WORD_W-1:0]       w_operand;
  logic [EXT_W-1:0]        w_ext;
  logic [WORD_W-1:0]       w_quot;
  logic [FBLEN12-1:0]      w_rem;

  assign w_dig_valid = (r_state == ST_EMIT);
  assign w_in_ready  = rst_n && (!w_dig_valid || (i_dig_ready && r_dig_last));
  assign w_accept    = i_in_valid && w_in_ready;
  assign w_take      = w_dig_valid && i_dig_ready;

  // Widened operand keeps the constant 377 representable when WORD_W < 9.
  assign w_operand = w_accept ? i_in_data : r_residue;
  assign w_ext     = {{FBLEN12{1'b0}}, w_operand};
  assign w_quot    = WORD_W'(w_ext / EXT_W'(RADIX));
  assign w_rem     = FBLEN12'(w_ext % EXT_W'(RADIX));

  always_comb begin
    w_state_nxt     = r_state;
    w_residue_nxt   = r_residue;
    w_cnt_nxt       = r_cnt;
    w_dig_data_nxt  = r_dig_data;
    w_dig_first_nxt = r_dig_first;
    w_dig_last_nxt  = r_dig_last;
    if (w_accept) begin
      w_state_nxt     = ST_EMIT;
      w_residue_nxt   = w_quot;
      w_cnt_nxt       = '0;
      w_dig_data_nxt  = w_rem;
      w_dig_first_nxt = 1'b1;
      w_dig_last_nxt  = (NDIG == 1);
    end else if (w_take) begin
      if (r_dig_last) begin
        w_state_nxt     = ST_IDLE;
        w_dig_first_nxt = 1'b0;
        w_dig_last_nxt  = 1'b0;
      end else begin
        w_residue_nxt   = w_quot;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_dig_data_nxt  = w_rem;
        w_dig_first_nxt = 1'b0;
        w_dig_last_nxt  = ((int'(r_cnt) + 1) == (NDIG - 1));
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_residue   <= '0;
      r_cnt       <= '0;
      r_dig_data  <= '0;
      r_dig_first <= 1'b0;
      r_dig_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_residue   <= w_residue_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dig_data  <= w_dig_data_nxt;
      r_dig_first <= w_dig_first_nxt;
      r_dig_last  <= w_dig_last_nxt;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_dig_data  = r_dig_data;
  assign o_dig_valid = w_dig_valid;
  assign o_dig_first = r_dig_first;
  assign o_dig_last  = r_dig_last;
  assign o_busy      = w_dig_valid;

endmodule

// File: tb/tb_ftf12_radix_packer.sv
// Directed testbench for ftf12_radix_packer: default 32-bit/4-digit instance
// plus a 17-bit/2-digit instance, with hand-computed radix-377 digits.
module tb_ftf12_radix_packer;

  logic        clock;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  dig_data;
  logic        dig_valid;
  logic        dig_ready;
  logic        dig_first;
  logic        dig_last;
  logic        busy;

  logic [16:0] n_in_data;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [8:0]  n_dig_data;
  logic        n_dig_valid;
  logic        n_dig_ready;
  logic        n_dig_first;
  logic        n_dig_last;
  logic        n_busy;

  int tests;
  int fails;

  ftf12_radix_packer #(.WORD_W(32), .NDIG(4)) u_dut (
    .clock(clock), .rst_n(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_dig_data(dig_data), .o_dig_valid(dig_valid), .i_dig_ready(dig_ready),
    .o_dig_first(dig_first), .o_dig_last(dig_last), .o_busy(busy)
  );

  ftf12_radix_packer #(.WORD_W(17), .NDIG(2)) u_narrow (
    .clock(clock), .rst_n(rst_n),
    .i_in_data(n_in_data), .i_in_valid(n_in_valid), .o_in_ready(n_in_ready),
    .o_dig_data(n_dig_data), .o_dig_valid(n_dig_valid), .i_dig_ready(n_dig_ready),
    .o_dig_first(n_dig_first), .o_dig_last(n_dig_last), .o_busy(n_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; dig_ready = 1'b1;
    n_in_data = '0; n_in_valid = 1'b0; n_dig_ready = 1'b1;
    #2;
    tests++;
    if ({dig_valid, dig_first, dig_last, busy, in_ready} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b, expected 00000",
               {dig_valid, dig_first, dig_last, busy, in_ready});
    end
    tests++;
    if (dig_data !== 9'd0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %0d, expected 0", dig_data);
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_release: got %b, expected 1", in_ready);
    end
    // dig_ready while idle must not start anything
    next_cycle();
    next_cycle();
    tests++;
    if (dig_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_dig_ready: valid %b busy %b, expected 0 0", dig_valid, busy);
    end
  endtask

  task automatic test_full_word();
    logic [8:0] exp_d [4];
    exp_d = '{9'd73, 9'd300, 9'd58, 9'd80};
    in_data = 32'hFFFF_FFFF; in_valid = 1'b1; dig_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (dig_valid !== 1'b1 || dig_data !== exp_d[k] ||
          dig_first !== (k == 0) || dig_last !== (k == 3)) begin
        fails++;
        $display("[TB] FAIL full_word digit %0d: got d=%0d v=%b f=%b l=%b, expected d=%0d v=1 f=%b l=%b",
                 k, dig_data, dig_valid, dig_first, dig_last, exp_d[k], k == 0, k == 3);
      end
      next_cycle();
    end
    tests++;
    if (dig_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_word_end: valid %b ready %b, expected 0 1", dig_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_d [8];
    exp_d = '{9'd246, 9'd2, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
    in_data = 32'd1000; in_valid = 1'b1; dig_ready = 1'b1;
    next_cycle();
    in_data = 32'd0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (dig_valid !== 1'b1 || dig_data !== exp_d[k] ||
          in_ready !== (k == 3 || k == 7) || dig_last !== (k == 3 || k == 7) ||
          dig_first !== (k == 0 || k == 4)) begin
        fails++;
        $display("[TB] FAIL back_to_back digit %0d: got d=%0d v=%b r=%b f=%b l=%b, expected d=%0d v=1 r=%b",
                 k, dig_data, dig_valid, in_ready, dig_first, dig_last, exp_d[k], (k == 3 || k == 7));
      end
      next_cycle();
      if (k == 3) in_valid = 1'b0;
    end
    tests++;
    if (dig_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL back_to_back_end: valid %b, expected 0", dig_valid);
    end
  endtask

  task automatic test_stall();
    logic [8:0] exp_d [4];
    int idx;
    exp_d = '{9'd246, 9'd2, 9'd0, 9'd0};
    in_data = 32'd1000; in_valid = 1'b1; dig_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      idx = (c + 2) / 3;
      dig_ready = (c % 3 == 0);
      #1;
      tests++;
      if (dig_valid !== 1'b1 || dig_data !== exp_d[idx] ||
          in_ready !== (c == 9) || dig_last !== (idx == 3)) begin
        fails++;
        $display("[TB] FAIL stall cycle %0d: got d=%0d v=%b r=%b l=%b, expected d=%0d v=1 r=%b l=%b",
                 c, dig_data, dig_valid, in_ready, dig_last, exp_d[idx], c == 9, idx == 3);
      end
      next_cycle();
    end
    dig_ready = 1'b1;
    tests++;
    if (dig_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_end: valid %b, expected 0", dig_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [8:0] exp_d [4];
    exp_d = '{9'd5, 9'd0, 9'd0, 9'd0};
    in_data = 32'hFFFF_FFFF; in_valid = 1'b1; dig_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    tests++;
    if (dig_data !== 9'd300) begin
      fails++;
      $display("[TB] FAIL mid_word_digit1: got %0d, expected 300", dig_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({dig_valid, dig_first, dig_last, busy, in_ready} !== 5'b0 || dig_data !== 9'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: flags %b data %0d, expected 00000 0",
               {dig_valid, dig_first, dig_last, busy, in_ready}, dig_data);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    tests++;
    if (dig_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: valid %b, expected 0", dig_valid);
    end
    in_data = 32'd5; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (dig_valid !== 1'b1 || dig_data !== exp_d[k] || dig_last !== (k == 3)) begin
        fails++;
        $display("[TB] FAIL after_reset digit %0d: got d=%0d v=%b l=%b, expected d=%0d v=1 l=%b",
                 k, dig_data, dig_valid, dig_last, exp_d[k], k == 3);
      end
      next_cycle();
    end
  endtask

  task automatic test_narrow();
    n_in_data = 17'd131071; n_in_valid = 1'b1; n_dig_ready = 1'b1;
    next_cycle();
    n_in_valid = 1'b0;
    tests++;
    if (n_dig_valid !== 1'b1 || n_dig_data !== 9'd252 || n_dig_first !== 1'b1 || n_dig_last !== 1'b0) begin
      fails++;
      $display("[TB] FAIL narrow_digit0: got d=%0d v=%b f=%b l=%b, expected d=252 v=1 f=1 l=0",
               n_dig_data, n_dig_valid, n_dig_first, n_dig_last);
    end
    next_cycle();
    tests++;
    if (n_dig_valid !== 1'b1 || n_dig_data !== 9'd347 || n_dig_first !== 1'b0 || n_dig_last !== 1'b1) begin
      fails++;
      $display("[TB] FAIL narrow_digit1: got d=%0d v=%b f=%b l=%b, expected d=347 v=1 f=0 l=1",
               n_dig_data, n_dig_valid, n_dig_first, n_dig_last);
    end
    next_cycle();
    tests++;
    if (n_dig_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL narrow_end: valid %b, expected 0", n_dig_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ftf12_radix_packer.md
# ftf12_radix_packer

Upstream feeder for the 12-line FTF encoder (`FTF_encoder_12`). It accepts binary words over a valid/ready handshake and converts each word into a fixed-length sequence of radix-377 digits, least-significant digit first. Each digit is a 9-bit value in the range 0..376, which is the full legal input range of the 12-line Fibonacci codec (`FBLEN12` from `FNS.vh`). The encoder latches one digit per `clock`, so a wide payload crosses the TSV bundle as NDIG consecutive codewords.

## Interface
- WORD_W, 32: input word width; legal range 1..64.
- NDIG, 4: digits emitted per word.
  - Must satisfy 377^NDIG ≥ 2^WORD_W; elaboration fails otherwise.
  - The digit width is fixed at `FBLEN12` (9 bits). The radix 377 is a localparam.
- clock  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WORD_W  word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the packer accepts in_data this cycle.
- dig_data  out  `FBLEN12`  current digit, always in the range 0..376.
- dig_valid  out  1  dig_data is valid.
- dig_ready  in  1  downstream (encoder wrapper) takes the digit this cycle.
- dig_first  out  1  dig_data is digit 0 of a word.
- dig_last  out  1  dig_data is digit NDIG-1 of a word.
- busy  out  1  a word is in conversion (equal to dig_valid).

## Operation
- Registers:
  - R: residue, WORD_W bits.
  - cnt: digit index, ceil(log2(NDIG)) bits.
  - dig_data, dig_valid, dig_first, dig_last.
- Two states: IDLE (dig_valid=0) and EMIT (dig_valid=1).
- in_ready = !dig_valid || (dig_ready && dig_last). This is a combinational path from dig_ready to in_ready. in_ready is forced to 0 while rst_n=0.
- Accept (in_valid && in_ready):
  - dig_data ← in_data mod 377; R ← in_data div 377; cnt ← 0.
  - dig_first ← 1; dig_last ← (NDIG==1); dig_valid ← 1; go to EMIT.
- Digit handshake (dig_valid && dig_ready), not last:
  - dig_data ← R mod 377; R ← R div 377; cnt ← cnt+1.
  - dig_first ← 0; dig_last ← (cnt+1 == NDIG-1).
- Digit handshake on the last digit:
  - With a simultaneous accept, the accept rule applies (back-to-back word, dig_valid stays 1).
  - Otherwise dig_valid ← 0, dig_first ← 0, dig_last ← 0, go to IDLE.
- Stall (dig_valid && !dig_ready): dig_data, dig_first, dig_last, R and cnt hold unchanged.
- Division and modulo by 377 are combinational constant operations on an WORD_W-bit operand. The remainder is zero-extended/truncated to 9 bits; the quotient is WORD_W bits.
- Reconstruction identity: word = Σ dig_k·377^k. For WORD_W=32 the top digit is ≤ 80.
- in_data is ignored when in_ready=0. Words are never dropped or reordered.

## Timing
- Reset (asynchronous on rst_n falling edge, held while low):
  - dig_valid=0, dig_first=0, dig_last=0, dig_data=0, busy=0, in_ready=0.
  - R=0, cnt=0.
- First cycle after rst_n deasserts: in_ready=1.
- Latency: accept at edge t makes digit 0 visible at t+1 (registered).
- Throughput: one digit per cycle with dig_ready held 1. A word occupies exactly NDIG cycles, and back-to-back words incur no bubble.
- Reset mid-word: the partial word is discarded immediately, with no further digits. After release the packer waits for a new accept.
- dig_ready asserted while dig_valid=0 has no effect.

## Test plan
- Word 0xFFFFFFFF, dig_ready=1 → digits 73, 300, 58, 80 on four consecutive cycles. dig_first on the first digit only, dig_last on the fourth only.
- Words 1000 then 0 presented back-to-back with in_valid held → 246, 2, 0, 0, 0, 0, 0, 0 with no gap in dig_valid. in_ready=1 exactly on the cycles carrying the two dig_last digits (plus the initial IDLE accept).
- Word 1000 with dig_ready toggled 1,0,0,1,... → each digit holds stable through the stalls. The sequence is still 246, 2, 0, 0, and in_ready stays 0 until the last digit is taken.
- Assert rst_n=0 after digit 1 of 0xFFFFFFFF → outputs clear asynchronously. After release, word 5 yields 5, 0, 0, 0 with no leftover 58/80.
- 10000 random 32-bit words through packer → `FTF_encoder_12` → `FNS_dec_12` → radix-377 reassembly.
  - Every reassembled word equals its input.
  - Every dig_data is ≤ 376.
  - No forbidden transition appears on the 12-bit tsv bus between adjacent lines.
- NDIG=2 with WORD_W=17 → word 131071 yields 252, 347. Elaboration with WORD_W=18, NDIG=2 fails (377² < 2^18).
